hazard_ctl: RTL and testbench
=============================

# hazard_ctl

Pipeline hazard and sequencing controller for the in-order RISC-V core. It generates the stall and clear controls for the PC, IF/ID and ID/EX pipeline registers. It covers load-use interlocks, multi-cycle divide/remainder occupancy of EX, outstanding memory accesses, branch/jump redirects and trap flushes. It sits beside the decode stage and drives the `stall`/`clear` inputs of the stage registers directly.

## Interface
- `DIV_CYCLES`, 64: EX occupancy of a div/rem op in cycles; legal range 1..255.
- `FLUSH_CYCLES`, 2: extra cycles the clears are held after a trap; legal range 0..15.

- `clk` input 1: core clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `id_valid` input 1: ID holds a real instruction.
- `id_rs1` input 5: ID source register 1.
- `id_rs2` input 5: ID source register 2.
- `id_uses_rs2` input 1: the ID instruction reads rs2 (not immediate form).
- `ex_valid` input 1: EX holds a real instruction.
- `ex_rd` input 5: EX destination register.
- `ex_load` input 1: EX instruction is a load, lr or amo.
- `ex_muldiv` input 1: EX instruction is div/divu/rem/remu (any width).
- `mem_req` input 1: MA has an access outstanding.
- `mem_ack` input 1: the MA access completes this cycle.
- `bj_en` input 1: EX resolved a taken branch or jump.
- `trap_en` input 1: a trap or mret is taken this cycle.
- `stall_pc` output 1: hold the PC.
- `stall_if_id` output 1: hold the IF/ID register.
- `stall_id_ex` output 1: hold the ID/EX register.
- `clear_if_id` output 1: zero the IF/ID register.
- `clear_id_ex` output 1: zero the ID/EX register (inserts a bubble).
- `busy` output 1: the FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE
  - DIV_BUSY: 8-bit down-counter `cnt`.
  - MEM_WAIT
  - FLUSH: 4-bit counter `fcnt`.
- Internal hazard terms:
  - `luse` = `id_valid & ex_valid & ex_load & (ex_rd!=0) & ((ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2))`.
  - `mwait` = `mem_req & ~mem_ack`.
  - `dstart` = IDLE & `ex_valid` & `ex_muldiv`.
  - `dhold` = `dstart` | (DIV_BUSY & `cnt`!=0).
- Priority, highest first: trap, mwait, dhold, luse, bj_en.
- Trap:
  - `clear_if_id` and `clear_id_ex` are asserted and all stalls are 0.
  - If `FLUSH_CYCLES`>0, the FSM goes to FLUSH with `fcnt`=`FLUSH_CYCLES`-1 from any state. An in-progress divide or memory wait is abandoned.
  - In FLUSH both clears are held and the stalls are 0. The FSM goes to IDLE when `fcnt`==0. A trap arriving during FLUSH reloads `fcnt`.
- mwait: all three stalls asserted, clears 0. FSM goes to MEM_WAIT; it returns to IDLE in the cycle after `mem_ack`.
- dhold: all three stalls asserted.
  - From IDLE with `dstart`, go to DIV_BUSY with `cnt`=`DIV_CYCLES`-1.
  - `cnt` decrements each cycle. At `cnt`==0 the stalls drop and the FSM returns to IDLE.
  - Total stall = `DIV_CYCLES` cycles.
  - `dstart` is not re-evaluated in the cycle DIV_BUSY exits. Back-to-back divides restart from IDLE on the next cycle.
- luse: `stall_pc`=`stall_if_id`=1, `stall_id_ex`=0, `clear_id_ex`=1. This is a one-cycle bubble; no FSM change.
- bj_en: `clear_if_id`=`clear_id_ex`=1. It is ignored while any stall term is active, because EX is held and the branch re-resolves.
- A trap or mwait during DIV_BUSY: a trap aborts the divide. mwait freezes `cnt` and keeps the state at DIV_BUSY while mwait is true.
- `busy` = (state != IDLE).

## Timing
- All outputs are combinational from the current state and inputs. State updates on the `clk` rising edge.
- Reset values: state IDLE, `cnt`=0, `fcnt`=0. All outputs are therefore 0 while `rst_n` is low.
- Reset mid-divide or mid-flush returns to IDLE immediately, with no residual stall.
- Load-use costs exactly 1 bubble. Divide costs `DIV_CYCLES` stall cycles. Trap costs 1+`FLUSH_CYCLES` clear cycles.
- Stall and clear are never both asserted for the same register.

## Configuration
- `HAZARD_MULDIV_EN`:
  - Defined: divide sequencing as above.
  - Undefined: `ex_muldiv` is ignored, DIV_BUSY and `cnt` are not built, and `dhold`=0. This is for builds where div/rem is single-cycle or absent.

## Test plan
- Load x5 in EX, ID `add x6,x5,x7` (`id_uses_rs2`=1) -> exactly 1 cycle with `stall_pc`=`stall_if_id`=1 and `clear_id_ex`=1. With `ex_rd`=0 -> no stall.
- `DIV_CYCLES`=4, div enters EX -> stalls high for 4 cycles and `busy` high for 3. A second div immediately after -> another 4 cycles.
- Trap during divide cycle 2 -> clears asserted, `FLUSH_CYCLES`=2 holds them 2 more cycles, then IDLE with no stall.
- `mem_req`=1 and `mem_ack` delayed 3 cycles -> 3 stall cycles. A simultaneous `bj_en` produces no clear until the stall drops.
- Assert `rst_n`=0 while in DIV_BUSY with `cnt`=30 -> outputs 0 asynchronously, state IDLE after release.
- Build without `HAZARD_MULDIV_EN` and hold `ex_muldiv`=1 -> no stall, `busy`=0.

Source files
------------

// File: rtl/hazard_ctl.sv
// Pipeline hazard/sequencing controller: stall and clear controls for PC, IF/ID, ID/EX.
// Latency: all outputs combinational from current state and inputs; state moves on clk rise.
// Backpressure: holds stages during memory waits, divides and load-use; a trap overrides all.
// Optional feature: define HAZARD_MULDIV_EN to build multi-cycle divide sequencing.
module hazard_ctl #(
  parameter int DIV_CYCLES   = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs2,
  input  logic       ex_valid,
  input  logic [4:0] ex_rd,
  input  logic       ex_load,
  input  logic       ex_muldiv,
  input  logic       mem_req,
  input  logic       mem_ack,
  input  logic       bj_en,
  input  logic       trap_en,
  output logic       stall_pc,
  output logic       stall_if_id,
  output logic       stall_id_ex,
  output logic       clear_if_id,
  output logic       clear_id_ex,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
`ifdef HAZARD_MULDIV_EN
    , DIV_BUSY = 2'd3
`endif
  } state_t;

  // Reload values; FLUSH_CYCLES of 0 never enters FLUSH, so its load is irrelevant.
  localparam logic [3:0] FLOAD = 4'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
  localparam logic [7:0] DLOAD = 8'(DIV_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] fcnt, fcnt_nxt;
  logic       luse, mwait, dhold;
  logic       s_pc, s_if_id, s_id_ex, c_if_id, c_id_ex;

`ifdef HAZARD_MULDIV_EN
  logic [7:0] cnt, cnt_nxt;
  logic       dstart;
  assign dstart = (state == IDLE) & ex_valid & ex_muldiv;
  assign dhold  = dstart | ((state == DIV_BUSY) & (cnt != 8'd0));
`else
  // Divide is single-cycle or absent in this build: nothing ever holds EX for it.
  logic [8:0] cfg_unused;
  assign cfg_unused = {ex_muldiv, DLOAD};
  assign dhold      = 1'b0;
`endif

  assign luse  = id_valid & ex_valid & ex_load & (ex_rd != 5'd0) &
                 ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
  assign mwait = mem_req & ~mem_ack;

  // Output decode by priority: trap/flush, memory wait, divide hold, load-use, redirect.
  always_comb begin
    s_pc    = 1'b0;
    s_if_id = 1'b0;
    s_id_ex = 1'b0;
    c_if_id = 1'b0;
    c_id_ex = 1'b0;
    if (trap_en || state == FLUSH) begin
      c_if_id = 1'b1;
      c_id_ex = 1'b1;
    end else if (mwait || dhold) begin
      s_pc    = 1'b1;
      s_if_id = 1'b1;
      s_id_ex = 1'b1;
    end else if (luse) begin
      s_pc    = 1'b1;
      s_if_id = 1'b1;
      c_id_ex = 1'b1;
    end else if (bj_en) begin
      c_if_id = 1'b1;
      c_id_ex = 1'b1;
    end
  end

  // Outputs are forced low while reset is held, whatever the inputs are doing.
  assign stall_pc    = rst_n & s_pc;
  assign stall_if_id = rst_n & s_if_id;
  assign stall_id_ex = rst_n & s_id_ex;
  assign clear_if_id = rst_n & c_if_id;
  assign clear_id_ex = rst_n & c_id_ex;
  assign busy        = rst_n & (state != IDLE);

  // Next-state: a trap abandons any divide or memory wait and (re)starts the flush window.
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
`ifdef HAZARD_MULDIV_EN
    cnt_nxt   = cnt;
`endif
    if (trap_en) begin
      if (FLUSH_CYCLES > 0) begin
        state_nxt = FLUSH;
        fcnt_nxt  = FLOAD;
      end else begin
        state_nxt = IDLE;
        fcnt_nxt  = 4'd0;
      end
`ifdef HAZARD_MULDIV_EN
      cnt_nxt = 8'd0;
`endif
    end else begin
      case (state)
        FLUSH: begin
          if (fcnt == 4'd0) state_nxt = IDLE;
          else              fcnt_nxt  = fcnt - 4'd1;
        end
        MEM_WAIT: begin
          if (!mwait) state_nxt = IDLE;
        end
`ifdef HAZARD_MULDIV_EN
        DIV_BUSY: begin
          // A memory wait freezes the divide; the last counted cycle hands back to IDLE.
          if (!mwait) begin
            if (cnt <= 8'd1) begin
              state_nxt = IDLE;
              cnt_nxt   = 8'd0;
            end else begin
              cnt_nxt = cnt - 8'd1;
            end
          end
        end
`endif
        default: begin
          if (mwait) begin
            state_nxt = MEM_WAIT;
`ifdef HAZARD_MULDIV_EN
          end else if (dstart) begin
            state_nxt = DIV_BUSY;
            cnt_nxt   = DLOAD;
`endif
          end
        end
      endcase
    end
  end

  // State register with asynchronous reset back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fcnt  <= 4'd0;
`ifdef HAZARD_MULDIV_EN
      cnt   <= 8'd0;
`endif
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
`ifdef HAZARD_MULDIV_EN
      cnt   <= cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_hazard_ctl.sv
// Bench for hazard_ctl: directed scenarios plus randomized traffic against a cycle model.
// Outputs are sampled on the falling edge; the model advances on the rising edge.
// Divide scenarios follow whether HAZARD_MULDIV_EN is defined for the build.
module tb_hazard_ctl;
  localparam int DC = 5;
  localparam int FC = 2;
`ifdef HAZARD_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid, id_uses_rs2, ex_valid, ex_load, ex_muldiv;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       mem_req, mem_ack, bj_en, trap_en;
  logic       stall_pc, stall_if_id, stall_id_ex, clear_if_id, clear_id_ex, busy;
  logic [5:0] outs;

  hazard_ctl #(.DIV_CYCLES(DC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_load(ex_load), .ex_muldiv(ex_muldiv),
    .mem_req(mem_req), .mem_ack(mem_ack), .bj_en(bj_en), .trap_en(trap_en),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .clear_if_id(clear_if_id), .clear_id_ex(clear_id_ex), .busy(busy)
  );

  assign outs = {stall_pc, stall_if_id, stall_id_ex, clear_if_id, clear_id_ex, busy};

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // Model: cycles of flush still owed, memory-wait flag, divide phase and stall cycles owed.
  int m_flush;
  bit m_mem;
  bit m_div;
  int m_owed;

  task automatic model_reset();
    m_flush = 0;
    m_mem   = 1'b0;
    m_div   = 1'b0;
    m_owed  = 0;
  endtask

  function automatic bit f_mwait();
    return mem_req && !mem_ack;
  endfunction

  function automatic bit f_dstart();
    return MD && m_flush == 0 && !m_mem && !m_div && ex_valid && ex_muldiv;
  endfunction

  function automatic logic [5:0] model_out();
    bit lu, hold;
    logic [5:0] r;
    if (!rst_n) return 6'b0;
    lu = id_valid && ex_valid && ex_load && ex_rd != 0 &&
         (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
    hold = f_dstart() || (m_div && m_owed > 0);
    r = 6'b0;
    if (trap_en || m_flush > 0)     r[2:1] = 2'b11;
    else if (f_mwait() || hold)     r[5:3] = 3'b111;
    else if (lu)                    begin r[5:4] = 2'b11; r[1] = 1'b1; end
    else if (bj_en)                 r[2:1] = 2'b11;
    r[0] = (m_flush > 0) || m_mem || m_div;
    return r;
  endfunction

  task automatic model_step();
    bit mw, ds;
    if (!rst_n) begin model_reset(); return; end
    mw = f_mwait();
    ds = f_dstart();
    if (trap_en) begin
      model_reset();
      m_flush = FC;
    end else if (m_flush > 0) begin
      m_flush--;
    end else if (m_div) begin
      if (!mw) begin
        if (m_owed <= 1) begin m_div = 1'b0; m_owed = 0; end
        else m_owed--;
      end
    end else if (mw) begin
      m_mem = 1'b1;
    end else if (m_mem) begin
      m_mem = 1'b0;
    end else if (ds) begin
      m_div  = 1'b1;
      m_owed = DC - 1;
    end
  endtask

  task automatic cyc(input string tag, input bit fixed, input logic [5:0] fexp);
    @(negedge clk);
    if (!rst_n) model_reset();
    check(tag, outs, model_out());
    if (fixed) check({tag, "_fix"}, outs, fexp);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drv(input logic iv, input logic [4:0] r1, input logic [4:0] r2, input logic u2,
                     input logic ev, input logic [4:0] rd, input logic ld, input logic md,
                     input logic mr, input logic ma, input logic bj, input logic tr);
    id_valid = iv; id_rs1 = r1; id_rs2 = r2; id_uses_rs2 = u2;
    ex_valid = ev; ex_rd = rd; ex_load = ld; ex_muldiv = md;
    mem_req = mr; mem_ack = ma; bj_en = bj; trap_en = tr;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 1'b0;
    cyc("reset", 1, 6'b000000);
    drv(1, 5, 7, 1, 1, 5, 1, 0, 0, 0, 1, 0);
    cyc("reset_inputs", 1, 6'b000000);
    rst_n = 1'b1;

    // Load-use through rs1, then the bubble has gone.
    drv(1, 5, 7, 1, 1, 5, 1, 0, 0, 0, 0, 0);
    cyc("luse_rs1", 1, 6'b110010);
    drv(1, 5, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("luse_after", 1, 6'b000000);
    drv(1, 9, 5, 1, 1, 5, 1, 0, 0, 0, 0, 0);
    cyc("luse_rs2", 1, 6'b110010);
    drv(1, 9, 5, 0, 1, 5, 1, 0, 0, 0, 0, 0);
    cyc("luse_imm", 1, 6'b000000);
    drv(1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    cyc("luse_x0", 1, 6'b000000);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("bj", 1, 6'b000110);

    // Memory wait of 3 cycles with a concurrent redirect.
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    cyc("mem0", 1, 6'b111000);
    cyc("mem1", 1, 6'b111001);
    cyc("mem2", 1, 6'b111001);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    cyc("mem_ack", 1, 6'b000111);
    idle();
    cyc("mem_done", 1, 6'b000000);

    // Trap from idle: one trap cycle then FC flush cycles.
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("trap", 1, 6'b000110);
    idle();
    for (int k = 0; k < FC; k++) cyc("flush", 1, 6'b000111);
    cyc("flush_done", 1, 6'b000000);

`ifdef HAZARD_MULDIV_EN
    // Two back-to-back divides.
    drv(0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 2 * DC; k++)
      cyc("div", 1, (k % DC == 0) ? 6'b111000 : 6'b111001);
    idle();
    cyc("div_done", 1, 6'b000000);
    // Trap in the third divide cycle.
    drv(0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 0, 0);
    cyc("dtrap0", 1, 6'b111000);
    cyc("dtrap1", 1, 6'b111001);
    trap_en = 1'b1;
    cyc("dtrap2", 1, 6'b000111);
    idle();
    for (int k = 0; k < FC; k++) cyc("dtrap_flush", 1, 6'b000111);
    cyc("dtrap_done", 1, 6'b000000);
    // Reset while the divide is in progress.
    drv(0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 0, 0);
    cyc("drst0", 1, 6'b111000);
    cyc("drst1", 1, 6'b111001);
    rst_n = 1'b0;
    cyc("drst_low", 1, 6'b000000);
    rst_n = 1'b1;
    idle();
    cyc("drst_after", 1, 6'b000000);
`else
    drv(0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc("nodiv", 1, 6'b000000);
    idle();
`endif

    // Randomized traffic with small register indices so hazards collide often.
    for (int n = 0; n < 3000; n++) begin
      rst_n       = ($urandom_range(0, 399) != 0);
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_uses_rs2 = 1'($urandom_range(0, 1));
      ex_valid    = ($urandom_range(0, 3) != 0);
      ex_rd       = 5'($urandom_range(0, 3));
      ex_load     = ($urandom_range(0, 2) == 0);
      ex_muldiv   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) mem_req = ~mem_req;
      mem_ack     = mem_req && ($urandom_range(0, 2) == 0);
      bj_en       = ($urandom_range(0, 3) == 0);
      trap_en     = ($urandom_range(0, 39) == 0);
      cyc("rand", 0, 6'b000000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
